// File: rtl/rev_counter_pkg.sv
// Shared constants and types for the reversible counter.
// Default width, terminal-count reference values and direction encoding.
package rev_counter_pkg;

  localparam int unsigned CNT_WIDTH = 16;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/rev_counter.sv
// Reversible (up/down) binary counter with parallel load and a
// combinational ripple carry/borrow flag for cascading.
module rev_counter
  import rev_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc
);

  dir_e dir;
  logic at_max;
  logic at_zero;

  assign dir     = dir_e'(s);
  assign at_max  = (cnt == {WIDTH{1'b1}});
  assign at_zero = (cnt == {WIDTH{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= din;
    end else if (en) begin
      if (dir == DIR_UP) cnt <= cnt + 1'b1;
      else               cnt <= cnt - 1'b1;
    end
  end

  // Flags the cycle whose next edge wraps; a pending load suppresses it.
  assign Rc = en & ~ld & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));

endmodule

// File: tb/tb_rev_counter.sv
// Self-checking bench for rev_counter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_rev_counter;

  localparam int unsigned W    = 16;
  localparam int unsigned MODV = 1 << W;
  localparam int unsigned MAXV = MODV - 1;

  logic         clk;
  logic         rst_n;
  logic         s;
  logic         en;
  logic         ld;
  logic [W-1:0] din;
  logic [W-1:0] cnt;
  logic         Rc;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned m;

  rev_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (s),
    .en   (en),
    .ld   (ld),
    .din  (din),
    .cnt  (cnt),
    .Rc   (Rc)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    vectors     = 0;
    miscompares = 0;
    m           = 0;
  end

  // Reference: count value as plain modular arithmetic
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   m = 0;
    else if (ld)  m = int'(din);
    else if (en)  m = s ? (m + 1) % MODV : (m + MODV - 1) % MODV;
  end

  function automatic bit model_rc();
    return en && !ld && ((s && m == MAXV) || (!s && m == 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cnt_vs_model", 32'(cnt), m);
    check("rc_vs_model", 32'(Rc), 32'(model_rc()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #10 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s     = 1'b1;
    en    = 1'b0;
    ld    = 1'b0;
    din   = '0;
    #30 rst_n = 1'b1;
    step();
    check("reset_cnt", 32'(cnt), 32'h0);

    // Count to 3, then assert reset mid-cycle
    en = 1'b1; s = 1'b1;
    repeat (3) step();
    check("pre_reset_cnt", 32'(cnt), 32'h3);
    s = 1'b0;
    #20 rst_n = 1'b0;
    #1;
    check("async_reset_cnt", 32'(cnt), 32'h0);
    check("async_reset_rc", 32'(Rc), 32'h1);
    #10 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Up five, down five
    s = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("up_cnt", 32'(cnt), 32'(i));
      check("up_rc", 32'(Rc), 32'h0);
    end
    check("model_up5", m, 32'd5);
    s = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      step();
      check("down_cnt", 32'(cnt), 32'(i));
      check("down_rc", 32'(Rc), (i == 0) ? 32'h1 : 32'h0);
    end

    // Underflow then immediate reversal
    step();
    check("underflow_cnt", 32'(cnt), 32'hFFFF);
    check("underflow_rc", 32'(Rc), 32'h0);
    s = 1'b1;
    #1;
    check("reverse_rc_same_cycle", 32'(Rc), 32'h1);
    step();
    check("overflow_cnt", 32'(cnt), 32'h0);

    // Load near top, then wrap
    ld = 1'b1; din = 16'hFFFE; s = 1'b1;
    step();
    check("load_cnt", 32'(cnt), 32'hFFFE);
    ld = 1'b0;
    step();
    check("load_up_cnt", 32'(cnt), 32'hFFFF);
    check("load_up_rc", 32'(Rc), 32'h1);
    ld = 1'b1; din = 16'h0042;
    #1;
    check("ld_masks_rc", 32'(Rc), 32'h0);
    ld = 1'b0;
    #1;
    step();
    check("load_wrap_cnt", 32'(cnt), 32'h0);

    // Hold with direction toggling, then load while disabled
    ld = 1'b1; din = 16'h1234;
    step();
    ld = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = ~s;
      step();
      check("hold_cnt", 32'(cnt), 32'h1234);
      check("hold_rc", 32'(Rc), 32'h0);
    end
    ld = 1'b1; din = 16'hBEEF;
    step();
    ld = 1'b0;
    check("load_no_en_cnt", 32'(cnt), 32'hBEEF);

    // Free run from reset with direction toggled every five cycles
    s = 1'b1; en = 1'b1;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (i > 0 && i % 5 == 0) s = ~s;
      step();
      check("freerun_range", 32'(cnt <= 16'd5), 32'h1);
      if (i % 10 == 9) begin
        check("freerun_zero", 32'(cnt), 32'h0);
        check("freerun_rc", 32'(Rc), 32'h1);
      end
    end

    // Randomized traffic, biased toward the wrap points
    for (int i = 0; i < 3000; i++) begin
      ld = ($urandom_range(7) == 0);
      en = ($urandom_range(3) != 0);
      s  = $urandom_range(1);
      case ($urandom_range(3))
        0: din = 16'hFFFF - 16'($urandom_range(2));
        1: din = 16'($urandom_range(2));
        default: din = 16'($urandom);
      endcase
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
